fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the decoder. Owns the program counter and issues in-order word requests to instruction memory over a request/grant/response handshake. Buffers returned words with their PCs in a small FIFO and presents them to the decoder through a valid/ready interface. Flushes on redirects (taken branch or jump) from execute, discarding in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `DEPTH`, 2, FIFO entries and maximum requests in flight; power of two, ≥2.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  word address of the request (byte address, [1:0]=0).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; responses are in order, at least 1 cycle after grant.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new fetch PC.
- `inst_valid`  out  1  `inst`/`inst_pc` valid to decoder.
- `inst`  out  32  instruction word to decoder.
- `inst_pc`  out  32  PC of `inst`.
- `inst_ready`  in  1  decoder consumes entry.
- `misalign_err`  out  1  one-cycle pulse, misaligned redirect seen.

## Operation
- State: `pc` (next request address), `rsp_pc` (PC of next expected response), `outstanding` (granted, not yet returned), `discard` (outstanding responses to drop), FIFO of {pc, word}.
- Reset: `pc`=`rsp_pc`=`RESET_PC`; `outstanding`=`discard`=0; FIFO empty; `imem_req`=0, `inst_valid`=0, `misalign_err`=0.
- pop = `inst_valid && inst_ready`.
- `imem_req` = !`redirect_valid` && (occupancy − pop + `outstanding`) < `DEPTH`; `imem_addr` = `pc`. Combinational path from `inst_ready` to `imem_req` is intended.
- Grant (`imem_req && imem_gnt`): `pc` += 4, `outstanding` += 1. PC wraps modulo 2^32.
- Response: `outstanding` −= 1. If `discard`>0: `discard` −= 1, word dropped, `rsp_pc` unchanged. Else push {`rsp_pc`, `imem_rdata`}, `rsp_pc` += 4.
- The credit rule guarantees the FIFO never overflows; push and pop in the same cycle on a full FIFO is legal.
- `inst_valid` = FIFO non-empty; `inst`/`inst_pc` = head entry, stable while `inst_valid && !inst_ready`.
- Redirect (highest priority): FIFO cleared; `pc`=`rsp_pc`=`redirect_pc` with [1:0] forced to 0; `discard` ← `outstanding` − `imem_rvalid` (a response arriving in the redirect cycle is dropped); `outstanding` ← `outstanding` − `imem_rvalid`; any pop that cycle is ignored; no request is issued that cycle.
- Back-to-back redirects: each recomputes `discard` from the current `outstanding`; the last one wins.

## Timing
- Redirect or reset release to first request: 1 cycle (request asserted the cycle after).
- Grant to `inst_valid`: response cycle + 1 (FIFO is registered, no bypass). With zero-wait memory (grant in cycle 0, rvalid in cycle 1), `inst_valid` is high in cycle 2.
- With `DEPTH`=2, 1-cycle memory, and `inst_ready` held high, sustained throughput is 1 instruction/cycle.
- `inst_valid` is low in the cycle after a redirect.
- Asserting `rst_n` mid-operation clears all state immediately. Responses arriving after reset release with `outstanding`=0 are a memory protocol violation and are ignored.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: a redirect with `redirect_pc[1:0]`≠0 drives `misalign_err`=1 for exactly the next cycle (registered). The redirect is still taken with [1:0] cleared.
- Not defined: `misalign_err` is tied 0 and low bits are cleared silently.

## Test plan
- Reset release, zero-wait memory, `inst_ready`=1, `RESET_PC`=0 -> `imem_addr` 0,4,8… on consecutive cycles; `inst_pc` 0,4,8 with matching words; first `inst_valid` 2 cycles after first grant.
- Stall: hold `inst_ready`=0 -> exactly `DEPTH` grants occur, then `imem_req`=0. Release -> entries drain in order with no loss or duplication.
- Redirect to 0x100 with 2 outstanding, responses returning 1 and 2 cycles later -> both words dropped; next `inst_pc`=0x100 with the word fetched from 0x100.
- Redirect in the same cycle as `imem_rvalid` and `inst_ready` -> response dropped, no pop counted, FIFO empty next cycle, `discard`=`outstanding`−1.
- `FETCH_ALIGN_CHECK_EN` defined, redirect to 0x202 -> `misalign_err` high one cycle, next `imem_addr`=0x200. Macro not defined -> same address, `misalign_err` stays 0.
- Wrap: redirect to 0xFFFF_FFFC -> `imem_addr` 0xFFFF_FFFC then 0x0000_0000; `inst_pc` follows.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the program counter, issues
//            in-order word requests to instruction memory, buffers returned
//            words with their PCs in a small FIFO and hands them to the
//            decoder over valid/ready. A redirect from execute flushes the
//            FIFO and drops responses that are still in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC : first PC fetched after reset
//   DEPTH    : FIFO entries and maximum requests in flight (power of two, >=2)
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_req/addr       : request valid / byte address (word aligned)
//   imem_gnt            : request accepted this cycle
//   imem_rvalid/rdata   : in-order response valid / instruction word
//   redirect_valid/pc   : flush and restart fetch at redirect_pc
//   inst_valid/inst/pc  : head FIFO entry presented to the decoder
//   inst_ready          : decoder consumes the head entry
//   misalign_err        : one-cycle pulse after a misaligned redirect
// Configuration
//   FETCH_ALIGN_CHECK_EN : when defined, misalign_err reports redirects whose
//                          target has nonzero bits [1:0]; otherwise tied 0.
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        misalign_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [31:0]      pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             run;

    logic [31:0]      fifo_pc   [DEPTH];
    logic [31:0]      fifo_word [DEPTH];

    logic             pop;
    logic             grant;
    logic             rsp;
    logic             drop;
    logic             push;
    logic [SUM_W-1:0] in_use;
    logic [31:0]      redirect_aligned;

    assign pop   = inst_valid && inst_ready;
    assign grant = imem_req && imem_gnt;
    // A response with nothing outstanding is a memory protocol violation
    // (e.g. a stale word after reset) and is ignored.
    assign rsp   = imem_rvalid && (outstanding != '0);
    assign drop  = rsp && (discard != '0);
    assign push  = rsp && (discard == '0);

    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    // Credit check: entries that will still be buffered after this cycle's
    // pop plus words already granted must leave room for one more. This
    // makes the FIFO impossible to overflow and gives the intended
    // combinational path from inst_ready to imem_req.
    assign in_use    = SUM_W'(count) + SUM_W'(outstanding) - SUM_W'(pop);
    assign imem_req  = run && !redirect_valid && (in_use < SUM_W'(DEPTH));
    assign imem_addr = pc;

    assign inst_valid = (count != '0);
    assign inst       = fifo_word[rd_ptr];
    assign inst_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            // Holds requests off for the cycle in which reset is released.
            run <= 1'b1;
            if (redirect_valid) begin
                pc          <= redirect_aligned;
                rsp_pc      <= redirect_aligned;
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                // A response landing in the redirect cycle is already gone,
                // so only the remainder has to be discarded later.
                outstanding <= outstanding - CNT_W'(rsp);
                discard     <= outstanding - CNT_W'(rsp);
            end else begin
                if (grant) begin
                    pc <= pc + 32'd4;
                end
                outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rsp);
                if (drop) begin
                    discard <= discard - CNT_W'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push && !redirect_valid) begin
            fifo_pc[wr_ptr]   <= rsp_pc;
            fifo_word[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_err = misalign_q;
`else
    // Low target bits are cleared silently in this build.
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign misalign_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A fixed-latency memory model
//            answers grants; directed phases load the expected PC stream into
//            a scoreboard queue and a monitor pops/compares on every consumed
//            instruction. Direct checks cover reset, request timing,
//            redirects, misalignment and PC wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int DEPTH = 2;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_MIS = 32'd1;
`else
    localparam logic [31:0] EXP_MIS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misalign_err;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .misalign_err   (misalign_err)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pop    = 0;
    int          n_grant  = 0;
    int          lat      = 1;
    int          mark;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5 ^ {a[9:2], 24'h0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic load_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory model: fixed latency, in-order, one response per cycle.
    initial begin
        logic        g;
        logic [31:0] ga;
        int          cyc;
        int          last_due;
        int          d;
        logic [31:0] pa [$];
        int          pd [$];
        cyc = 0; last_due = 0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            g  = rst_n && imem_req && imem_gnt;
            ga = imem_addr;
            @(posedge clk);
            if (g) begin
                d = cyc + lat;
                if (d <= last_due) d = last_due + 1;
                pa.push_back(ga);
                pd.push_back(d);
                last_due = d;
                n_grant++;
            end
            cyc++;
            #1;
            if (!rst_n) begin
                pa.delete(); pd.delete();
                last_due = cyc;
            end
            if (pd.size() != 0 && pd[0] == cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memfn(pa[0]);
                void'(pa.pop_front());
                void'(pd.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    // Scoreboard monitor: every accepted instruction must match the head of
    // the expected stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc %h, expected no instruction", inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", inst_pc, e);
                    chk("sb_word", inst, memfn(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'h0; inst_ready = 1'b0;
        load_exp(32'h0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_mis", {31'b0, misalign_err}, 32'd0);

        // Release and stream with zero-wait memory
        @(posedge clk); #1;
        rst_n = 1'b1; inst_ready = 1'b1;
        @(negedge clk);
        chk("rel_req_low", {31'b0, imem_req}, 32'd0);
        adv(1); @(negedge clk);
        chk("s_req0", {31'b0, imem_req}, 32'd1);
        chk("s_addr0", imem_addr, 32'h0);
        adv(1); @(negedge clk);
        chk("s_addr4", imem_addr, 32'h4);
        chk("s_valid_lat1", {31'b0, inst_valid}, 32'd0);
        adv(1); @(negedge clk);
        chk("s_addr8", imem_addr, 32'h8);
        chk("s_valid_lat2", {31'b0, inst_valid}, 32'd1);
        adv(1); @(negedge clk);
        chk("s_addr12", imem_addr, 32'hC);
        // Grant withheld: address must hold
        adv(1); imem_gnt = 1'b0; @(negedge clk);
        chk("gnt_hold_a", imem_addr, 32'h10);
        adv(1); @(negedge clk);
        chk("gnt_hold_b", imem_addr, 32'h10);
        chk("gnt_hold_req", {31'b0, imem_req}, 32'd1);
        adv(1); imem_gnt = 1'b1;
        adv(6);
        chk("p1_progress", {31'b0, n_pop >= 6}, 32'd1);

        // Stall: FIFO fills to DEPTH, requests stop
        inst_ready = 1'b0;
        adv(8); @(negedge clk);
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_buffered", 32'(n_grant - n_pop), 32'(DEPTH));
        chk("stall_head", inst_pc, exp_q[0]);
        adv(1); inst_ready = 1'b1;
        mark = n_pop;
        adv(6);
        chk("drain_progress", {31'b0, n_pop > mark + 2}, 32'd1);

        // Redirect with two requests in flight (latency 3)
        redirect_valid = 1'b1; redirect_pc = 32'h40; lat = 3;
        load_exp(32'h40);
        adv(1); redirect_valid = 1'b0; @(negedge clk);
        chk("rd1_valid", {31'b0, inst_valid}, 32'd0);
        chk("rd1_addr", imem_addr, 32'h40);
        adv(1); @(negedge clk);
        chk("rd1_addr2", imem_addr, 32'h44);
        adv(1); redirect_valid = 1'b1; redirect_pc = 32'h100;
        load_exp(32'h100);
        @(negedge clk);
        chk("rd2_req_low", {31'b0, imem_req}, 32'd0);
        adv(1); redirect_valid = 1'b0; @(negedge clk);
        chk("rd2_req_wait", {31'b0, imem_req}, 32'd0);
        adv(1); @(negedge clk);
        chk("rd2_addr", imem_addr, 32'h100);
        mark = n_pop;
        adv(20);
        chk("rd2_progress", {31'b0, n_pop > mark}, 32'd1);

        // Redirect coinciding with a response and a pop
        lat = 1;
        adv(10);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        load_exp(32'h300);
        @(negedge clk);
        chk("rd3_pre_valid", {31'b0, inst_valid}, 32'd1);
        chk("rd3_pre_rvalid", {31'b0, imem_rvalid}, 32'd1);
        adv(1); redirect_valid = 1'b0; @(negedge clk);
        chk("rd3_empty", {31'b0, inst_valid}, 32'd0);
        chk("rd3_req", {31'b0, imem_req}, 32'd1);
        chk("rd3_addr", imem_addr, 32'h300);
        mark = n_pop;
        adv(6);
        chk("rd3_progress", {31'b0, n_pop > mark}, 32'd1);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        load_exp(32'h200);
        adv(1); redirect_valid = 1'b0; @(negedge clk);
        chk("mis_addr", imem_addr, 32'h200);
        chk("mis_pulse", {31'b0, misalign_err}, EXP_MIS);
        adv(1); @(negedge clk);
        chk("mis_clear", {31'b0, misalign_err}, 32'd0);
        adv(5);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        load_exp(32'hFFFF_FFFC);
        adv(1); redirect_valid = 1'b0; @(negedge clk);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        adv(1); @(negedge clk);
        chk("wrap_addr1", imem_addr, 32'h0);
        mark = n_pop;
        adv(8);
        chk("wrap_progress", {31'b0, n_pop > mark + 2}, 32'd1);

        // Mid-operation reset
        rst_n = 1'b0;
        load_exp(32'h0);
        #1;
        chk("mrst_valid", {31'b0, inst_valid}, 32'd0);
        chk("mrst_req", {31'b0, imem_req}, 32'd0);
        adv(2); rst_n = 1'b1; @(negedge clk);
        chk("mrst_rel_req", {31'b0, imem_req}, 32'd0);
        adv(1); @(negedge clk);
        chk("mrst_addr", imem_addr, 32'h0);
        mark = n_pop;
        adv(10);
        chk("mrst_progress", {31'b0, n_pop > mark + 4}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
